transport_send: RTL and testbench

- Transmit side of the FPGA-telephony transport layer.
- Accepts one-shot control requests and a stream of 16-bit voice samples from the application layer, and buffers the voice samples in an internal FIFO.
- Serialises packets one byte per clock onto packetOut for the link/physical layer.
- busy tells upstream logic that a packet is in flight.

---
 rtl/transport_send.sv | 184 ++++++++++++++++++
 tb/tb_transport_send.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/transport_send.sv
// Transport-layer transmit path: voice FIFO, edge-triggered
// requests and a byte-serial packet framer.
module transport_send #(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  cmd,
  input  logic [15:0] data,
  input  logic        sendData,
  output logic        sending,
  output logic [7:0]  packetOut,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [5:0] FULL = 6'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HEADER,
    S_MSB,
    S_LSB
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0]    r_prev_cmd;
  logic          r_prev_send;
  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [5:0]    r_count;
  logic [15:0]   r_word;
  logic [1:0]    r_type;
  logic [5:0]    r_left;

  logic        w_ctrl_trig;
  logic        w_send_trig;
  logic        w_accept;
  logic        w_start_ctrl;
  logic        w_start_voice;
  logic        w_push;
  logic        w_pop;
  logic [15:0] w_word;
  logic        w_busy;
  logic        w_sending;
  logic [7:0]  w_byte;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_ctrl_trig = (cmd == 2'b01) && (r_prev_cmd != 2'b01);
  assign w_send_trig = sendData && !r_prev_send;

  // Start only when fully idle, including the final-byte cycle.
  assign w_accept      = (r_state == S_IDLE) && !busy;
  assign w_start_ctrl  = w_accept && w_ctrl_trig;
  assign w_start_voice = w_accept && !w_ctrl_trig &&
                         w_send_trig && (r_count != '0);

  assign w_push = (cmd == 2'b10) && (r_count < FULL);
  assign w_pop  = (r_state == S_LSB) && (r_type == 2'b10);
  assign w_word = (r_type == 2'b10) ? r_mem[r_rd] : r_word;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start_ctrl || w_start_voice) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD:   w_next = S_HEADER;
      S_HEADER: w_next = S_MSB;
      S_MSB:    w_next = S_LSB;
      S_LSB:    w_next = (r_left > 6'd1) ? S_MSB : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy    = 1'b0;
    w_sending = 1'b0;
    w_byte    = 8'h00;
    unique case (1'b1)
      (r_state == S_LOAD): begin
        w_busy = 1'b1;
      end
      (r_state == S_HEADER): begin
        w_busy    = 1'b1;
        w_sending = 1'b1;
        w_byte    = {r_type, r_left};
      end
      (r_state == S_MSB): begin
        w_busy    = 1'b1;
        w_sending = 1'b1;
        w_byte    = w_word[15:8];
      end
      (r_state == S_LSB): begin
        w_busy    = 1'b1;
        w_sending = 1'b1;
        w_byte    = w_word[7:0];
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sending   <= 1'b0;
      packetOut <= 8'h00;
      busy      <= 1'b0;
    end else begin
      sending   <= w_sending;
      packetOut <= w_byte;
      busy      <= w_busy;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_prev_cmd  <= 2'b00;
      r_prev_send <= 1'b0;
      r_word      <= '0;
      r_type      <= 2'b00;
      r_left      <= '0;
    end else begin
      r_prev_cmd  <= cmd;
      r_prev_send <= sendData;
      if (w_start_ctrl) begin
        r_word <= data;
        r_type <= 2'b01;
        r_left <= 6'd1;
      end else if (w_start_voice) begin
        r_type <= 2'b10;
        r_left <= r_count;
      end else if (r_state == S_LSB) begin
        r_left <= r_left - 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wr <= inc(r_wr);
      end
      if (w_pop) begin
        r_rd <= inc(r_rd);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 6'd1;
        2'b01:   r_count <= r_count - 6'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= data;
    end
  end

endmodule

// File: tb/tb_transport_send.sv
// Directed bench for transport_send with a queue-based packet
// model checked every cycle, plus literal byte expectations.
module tb_transport_send;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cmd;
  logic [15:0] data;
  logic        sendData;
  logic        sending;
  logic [7:0]  packetOut;
  logic        busy;

  int vectors = 0;
  int errors  = 0;
  bit run     = 0;

  transport_send #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .cmd(cmd),
    .data(data),
    .sendData(sendData),
    .sending(sending),
    .packetOut(packetOut),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       b;
    logic       s;
    logic [7:0] d;
    logic       p;
  } ent_t;

  logic [15:0] q[$];
  ent_t        tl[$];
  logic [1:0]  m_pc;
  logic        m_ps;
  logic        m_busy = 1'b0;
  logic        m_snd  = 1'b0;
  logic [7:0]  m_byte = 8'h00;

  ent_t        e;
  bit          ctl;
  bit          snd;
  bit          acc;
  bit          full;
  int          n0;
  logic [15:0] w;

  // Model: a packet is a list of per-cycle output entries.
  always @(posedge clk) begin
    if (!reset) begin
      q.delete();
      tl.delete();
      m_pc   = 2'b00;
      m_ps   = 1'b0;
      m_busy = 1'b0;
      m_snd  = 1'b0;
      m_byte = 8'h00;
    end else begin
      ctl  = (cmd == 2'b01) && (m_pc != 2'b01);
      snd  = sendData && !m_ps;
      acc  = (tl.size() == 0) && !m_busy;
      full = q.size() >= DEPTH;
      n0   = q.size();
      if (tl.size() > 0) begin
        e      = tl.pop_front();
        m_busy = e.b;
        m_snd  = e.s;
        m_byte = e.d;
        if (e.p) void'(q.pop_front());
      end else begin
        m_busy = 1'b0;
        m_snd  = 1'b0;
        m_byte = 8'h00;
      end
      if (acc && ctl) begin
        tl.push_back('{1'b1, 1'b0, 8'h00, 1'b0});
        tl.push_back('{1'b1, 1'b1, 8'h41, 1'b0});
        tl.push_back('{1'b1, 1'b1, data[15:8], 1'b0});
        tl.push_back('{1'b1, 1'b1, data[7:0], 1'b0});
      end else if (acc && snd && n0 > 0) begin
        tl.push_back('{1'b1, 1'b0, 8'h00, 1'b0});
        tl.push_back('{1'b1, 1'b1, 8'h80 | 8'(n0), 1'b0});
        for (int i = 0; i < n0; i++) begin
          w = q[i];
          tl.push_back('{1'b1, 1'b1, w[15:8], 1'b0});
          tl.push_back('{1'b1, 1'b1, w[7:0], 1'b1});
        end
      end
      if (cmd == 2'b10 && !full) q.push_back(data);
      m_pc = cmd;
      m_ps = sendData;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      vectors++;
      if ({sending, packetOut, busy} !== {m_snd, m_byte, m_busy}) begin
        errors++;
        $display("FAIL model t=%0t got s=%b b=%h busy=%b want s=%b b=%h busy=%b",
                 $time, sending, packetOut, busy, m_snd, m_byte, m_busy);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  initial begin
    reset    = 1'b0;
    cmd      = 2'b01;
    data     = 16'h0000;
    sendData = 1'b1;
    tick();
    run = 1;
    for (int i = 0; i < 5; i++) begin
      chk("rst_out", {sending, busy, packetOut[5:0]}, 8'h00);
      chk("rst_byte", packetOut, 8'h00);
      if (i < 4) tick();
    end
    reset    = 1'b1;
    cmd      = 2'b00;
    sendData = 1'b0;
    tick(3);
    chk("post_rst_busy", {7'd0, busy}, 8'h00);

    // Control packet, cmd held two cycles
    data = 16'h8000;
    cmd  = 2'b01;
    tick();
    chk("ctl_busy_n", {7'd0, busy}, 8'h00);
    tick();
    chk("ctl_load", {6'd0, busy, sending}, 8'h02);
    cmd = 2'b00;
    tick();
    chk("ctl_hdr", packetOut, 8'h41);
    tick();
    chk("ctl_msb", packetOut, 8'h80);
    tick();
    chk("ctl_lsb", {sending, busy, packetOut[5:0]}, 8'hC0);
    tick();
    chk("ctl_end", {6'd0, busy, sending}, 8'h00);
    tick(4);
    chk("ctl_once", {6'd0, busy, sending}, 8'h00);

    // Voice overflow: 40 captured, 32 kept
    for (int i = 0; i < 40; i++) begin
      cmd  = 2'b10;
      data = 16'h1000 + 16'(i);
      tick();
    end
    cmd      = 2'b00;
    sendData = 1'b1;
    tick(2);
    sendData = 1'b0;
    tick();
    chk("ovf_hdr", packetOut, 8'hA0);
    for (int k = 0; k < 32; k++) begin
      tick();
      chk("ovf_msb", packetOut, 8'h10);
      tick();
      chk("ovf_lsb", packetOut, 8'(k));
    end
    tick();
    chk("ovf_end", {6'd0, busy, sending}, 8'h00);

    // Empty flush
    sendData = 1'b1;
    tick();
    sendData = 1'b0;
    tick(4);
    chk("empty_flush", {6'd0, busy, sending}, 8'h00);

    // Capture continuing during transmission
    for (int i = 0; i < 3; i++) begin
      cmd  = 2'b10;
      data = 16'hA000 + 16'(i);
      tick();
    end
    cmd      = 2'b00;
    sendData = 1'b1;
    tick();
    sendData = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cmd  = 2'b10;
      data = 16'hB000 + 16'(i);
      tick();
      if (i == 1) chk("cc_hdr", packetOut, 8'h83);
      if (i == 7) chk("cc_last", packetOut, 8'h02);
    end
    cmd = 2'b00;
    tick(3);
    sendData = 1'b1;
    tick();
    sendData = 1'b0;
    tick(2);
    chk("cc2_hdr", packetOut, 8'h8A);
    tick();
    chk("cc2_msb", packetOut, 8'hB0);
    tick(22);
    chk("cc2_end", {6'd0, busy, sending}, 8'h00);

    // Simultaneous control and send triggers
    for (int i = 0; i < 2; i++) begin
      cmd  = 2'b10;
      data = 16'hC000 + 16'(i);
      tick();
    end
    cmd      = 2'b01;
    data     = 16'h1234;
    sendData = 1'b1;
    tick();
    cmd      = 2'b00;
    sendData = 1'b0;
    tick(2);
    chk("sim_hdr", packetOut, 8'h41);
    tick();
    chk("sim_msb", packetOut, 8'h12);
    tick();
    chk("sim_lsb", packetOut, 8'h34);
    tick(5);
    chk("sim_only", {6'd0, busy, sending}, 8'h00);

    // Reset during an MSB byte
    sendData = 1'b1;
    tick();
    sendData = 1'b0;
    tick(2);
    chk("mid_hdr", packetOut, 8'h82);
    tick();
    chk("mid_msb", packetOut, 8'hC0);
    reset = 1'b0;
    tick();
    chk("mid_abort", {sending, busy, packetOut[5:0]}, 8'h00);
    reset = 1'b1;
    tick(2);
    sendData = 1'b1;
    tick();
    sendData = 1'b0;
    tick(4);
    chk("mid_fifo_empty", {6'd0, busy, sending}, 8'h00);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
